qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Synthesizable device-side model of the quad-SPI flash: it answers the host flash controller's command sequence and serves read data from an on-chip byte memory.
- Used for on-FPGA loopback bring-up and as the bench counterpart for the controller.
- Runs in the serial-clock domain; pin DDR registers (SB_IO) sit outside, so rise/fall nibbles appear as parallel ports.

Parameters:
- DUMMY_CYCLES, 7, dummy clocks between mode byte and first data byte (1..15)
- QE_RESET, 1'b0, reset value of SR2[1] (Quad Enable)
- ADDR_MASK, 24'hFFFFFF, read address wrap mask (power-of-2 memory size minus 1)

Ports:
- clk  in  1  serial flash clock (SCLK), free-running
- reset  in  1  async, active-high
- cs_n  in  1  chip select, sampled on clk rise
- io_in_rise  in  4  IO3..IO0 sampled at rising edge
- io_in_fall  in  4  IO3..IO0 sampled at falling edge
- io_out_rise  out  4  nibble driven for rising half
- io_out_fall  out  4  nibble driven for falling half
- io_oe  out  4  per-pin output enable
- mem_en  out  1  memory read strobe
- mem_addr  out  24  memory byte address
- mem_rdata  in  8  byte, valid the cycle after mem_en (latency 1)
- sr2  out  8  status register-2 (bit1 QE, others 0)
- cont_mode  out  1  continuous-read mode armed

Behaviour:
- Reset (async): state IDLE, io_oe=0, io_out_*=0, mem_en=0, mem_addr=0, sr2={6'b0,QE_RESET,1'b0}, WEL=0, cont_mode=0.
- cs_n high on any rising edge: state goes to IDLE next cycle and io_oe=0 that same cycle (combinational gate on cs_n). SR2 and cont_mode are retained. Any partial transaction is abandoned.
- Cycle k counts from the first rising edge with cs_n low (k=0).
- DDR byte convention: the rising nibble carries bits[7:4] and the falling nibble carries bits[3:0].
- IDLE -> CMD if cont_mode=0; IDLE -> ADDR if cont_mode=1.
- CMD: 8 SDR bits sampled from io_in_rise[0], MSB first, at k=0..7. Decode at k=7:
  - 0xED (only when QE=1): go to ADDR.
  - 0x06: set WEL, go to IGNORE.
  - 0x31: go to WRSR.
  - 0x35: go to RDSR.
  - anything else, or 0xED with QE=0: go to IGNORE.
- ADDR: 3 cycles, one DDR byte each, A23..A16, A15..A8, A7..A0. On the last address cycle: mem_en=1, mem_addr=addr&ADDR_MASK.
- MODE: 1 DDR byte. cont_mode <= (M[5:4]==2'b10).
- DUMMY: DUMMY_CYCLES cycles with io_oe=0. Read data is buffered internally.
- DATA: io_oe=4'hF. Each cycle drives one byte, then mem_addr <= (mem_addr+1)&ADDR_MASK with mem_en=1 (prefetch). Continues until cs_n rises; the address wraps silently.
- Data timing:
  - Command entry: first data byte in cycle k=12+DUMMY_CYCLES.
  - Continuous entry: first data byte in cycle k=4+DUMMY_CYCLES.
- WRSR: 8 SDR bits on IO0. On the 8th bit, if WEL=1, SR2[1] <= bit1 and WEL <= 0; other SR2 bits stay 0. Any further bits are ignored. If WEL=0 there is no change.
- RDSR: io_oe=4'b0010. Drives SR2 MSB-first on IO1 with io_out_rise[1]=io_out_fall[1]=bit, one bit per cycle, repeating every 8 cycles.
- IGNORE: io_oe=0 until cs_n high.
- A QE write to 0 takes effect for the next 0xED. cont_mode is not cleared by WRSR.
- Simultaneous reset and cs_n edge: reset wins.

Test Plan:
- Reset, then cs_n low with 0xED, QE=0 -> io_oe stays 0 for 40 cycles; mem_en never asserts.
- 0x06 / cs_n high / 0x31 with data 0x02 / cs_n high / 0x35 -> IO1 bitstream 0,0,0,0,0,0,1,0 repeating; sr2=8'h02.
- QE=1, memory[i]=i[7:0]; 0xED, addr 0x000010, M=0x00 -> cycle 19 (DUMMY_CYCLES=7) rise/fall nibbles 1/0, then 1/1, 1/2; cont_mode=0.
- Same read with M=0x20, cs_n high for 2 cycles, then address 0x0000FE with no command -> cont_mode=1; data at k=11 is 0xFE, then 0xFF, 0x00 (wrap with ADDR_MASK=24'h0000FF).
- cs_n raised during DUMMY at k=14 -> io_oe=0 the same cycle; the next transaction decodes a fresh command correctly.
- Reset asserted mid-DATA -> all outputs return to 0 immediately; sr2 returns to QE_RESET; cont_mode=0.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// Device-side quad-SPI flash model: decodes host commands, serves DDR quad reads from a byte memory.
// Latency: first read byte at k=12+DUMMY_CYCLES (command entry) or k=4+DUMMY_CYCLES (continuous entry).
// Backpressure: none; the host owns SCLK and cs_n, and raising cs_n abandons any transaction at once.
//
// Ports:
//   clk, reset          serial flash clock (free-running), async active-high reset
//   cs_n                chip select, sampled on clk rise
//   io_in_rise/fall     IO3..IO0 captured at the rising / falling edge by external DDR pin registers
//   io_out_rise/fall    nibble driven in the rising / falling half of the cycle
//   io_oe               per-pin output enable, forced low combinationally while cs_n is high
//   mem_en, mem_addr    byte memory read request; mem_rdata returns one cycle after mem_en
//   sr2, cont_mode      status register-2 (bit1 = QE) and continuous-read armed flag
module qspi_flash_responder #(
    parameter int unsigned DUMMY_CYCLES = 7,
    parameter logic        QE_RESET     = 1'b0,
    parameter logic [23:0] ADDR_MASK    = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic [3:0]  io_in_rise,
    input  logic [3:0]  io_in_fall,
    output logic [3:0]  io_out_rise,
    output logic [3:0]  io_out_fall,
    output logic [3:0]  io_oe,
    output logic        mem_en,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  sr2,
    output logic        cont_mode
);

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
    localparam logic [7:0] CMD_QREAD  = 8'hED;
    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_WRSR   = 8'h31;
    localparam logic [7:0] CMD_RDSR   = 8'h35;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        WRSR,
        RDSR,
        IGNORE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;        // bit / byte / dummy-cycle counter, meaning depends on state
    logic [6:0]  sh;         // SDR bits collected so far on IO0
    logic [15:0] addr_sr;    // first two address bytes
    logic        wel;
    logic        qe;
    logic [3:0]  oe_q;
    logic        pend;       // mem_rdata holds a requested byte this cycle
    logic [7:0]  buf0;
    logic [7:0]  buf1;
    logic [1:0]  buf_cnt;

    logic [7:0]  cmd_byte;
    logic [7:0]  ddr_byte;
    logic        pop;

    assign cmd_byte  = {sh, io_in_rise[0]};
    assign ddr_byte  = {io_in_rise, io_in_fall};
    assign pop       = (state == DATA);
    assign sr2       = {6'b0, qe, 1'b0};
    assign io_oe     = cs_n ? 4'h0 : oe_q;

    // The memory answers two edges after a request is issued, so the read
    // pipeline runs two bytes ahead: bytes a and a+1 are requested at the last
    // address cycle and the mode cycle, a+2 at the last dummy cycle, and every
    // data cycle requests the byte two ahead of the one it drives. A two-entry
    // buffer absorbs the gap when the dummy phase is longer than the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            sh          <= 7'd0;
            addr_sr     <= 16'd0;
            wel         <= 1'b0;
            qe          <= QE_RESET;
            cont_mode   <= 1'b0;
            oe_q        <= 4'h0;
            io_out_rise <= 4'h0;
            io_out_fall <= 4'h0;
            mem_en      <= 1'b0;
            mem_addr    <= 24'd0;
            pend        <= 1'b0;
            buf0        <= 8'd0;
            buf1        <= 8'd0;
            buf_cnt     <= 2'd0;
        end else begin
            mem_en <= 1'b0;
            pend   <= mem_en;
            if (cs_n) begin
                state       <= IDLE;
                cnt         <= 4'd0;
                oe_q        <= 4'h0;
                io_out_rise <= 4'h0;
                io_out_fall <= 4'h0;
                pend        <= 1'b0;
                buf_cnt     <= 2'd0;
            end else begin
                oe_q        <= 4'h0;
                io_out_rise <= 4'h0;
                io_out_fall <= 4'h0;
                case (state)
                    // First selected cycle is already bit 0 of the command,
                    // or the first address byte when continuous mode is armed.
                    IDLE: begin
                        cnt <= 4'd1;
                        if (cont_mode) begin
                            addr_sr <= {addr_sr[7:0], ddr_byte};
                            state   <= ADDR;
                        end else begin
                            sh    <= {sh[5:0], io_in_rise[0]};
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        sh  <= {sh[5:0], io_in_rise[0]};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (cmd_byte == CMD_QREAD && qe) begin
                                state <= ADDR;
                            end else if (cmd_byte == CMD_WREN) begin
                                wel   <= 1'b1;
                                state <= IGNORE;
                            end else if (cmd_byte == CMD_WRSR) begin
                                state <= WRSR;
                            end else if (cmd_byte == CMD_RDSR) begin
                                state <= RDSR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR: begin
                        if (cnt == 4'd2) begin
                            mem_en   <= 1'b1;
                            mem_addr <= {addr_sr, ddr_byte} & ADDR_MASK;
                            cnt      <= 4'd0;
                            state    <= MODE;
                        end else begin
                            addr_sr <= {addr_sr[7:0], ddr_byte};
                            cnt     <= cnt + 4'd1;
                        end
                    end
                    MODE: begin
                        cont_mode <= (ddr_byte[5:4] == 2'b10);
                        mem_en    <= 1'b1;
                        mem_addr  <= (mem_addr + 24'd1) & ADDR_MASK;
                        cnt       <= 4'd0;
                        state     <= DUMMY;
                    end
                    DUMMY: begin
                        if (cnt == DUMMY_LAST) begin
                            mem_en   <= 1'b1;
                            mem_addr <= (mem_addr + 24'd1) & ADDR_MASK;
                            state    <= DATA;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        oe_q        <= 4'hF;
                        io_out_rise <= buf0[7:4];
                        io_out_fall <= buf0[3:0];
                        mem_en      <= 1'b1;
                        mem_addr    <= (mem_addr + 24'd1) & ADDR_MASK;
                    end
                    WRSR: begin
                        sh  <= {sh[5:0], io_in_rise[0]};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            // sh[0] holds bit1 of the byte once the eighth bit arrives
                            if (wel) begin
                                qe  <= sh[0];
                                wel <= 1'b0;
                            end
                            state <= IGNORE;
                        end
                    end
                    RDSR: begin
                        oe_q           <= 4'b0010;
                        io_out_rise[1] <= sr2[3'd7 - cnt[2:0]];
                        io_out_fall[1] <= sr2[3'd7 - cnt[2:0]];
                        cnt            <= {1'b0, cnt[2:0] + 3'd1};
                    end
                    IGNORE: begin
                        state <= IGNORE;
                    end
                    default: begin
                        state <= IGNORE;
                    end
                endcase

                if (pend && pop) begin
                    if (buf_cnt == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= mem_rdata;
                    end else begin
                        buf0 <= mem_rdata;
                    end
                end else if (pend) begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= mem_rdata;
                    end else begin
                        buf1 <= mem_rdata;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end else if (pop) begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Testbench for qspi_flash_responder: drives host command sequences and checks
// the device against a transaction-level model of status bits, read timing and
// memory contents.
module tb_qspi_flash_responder;

    localparam int          DUMMY  = 7;
    localparam logic        QE_RST = 1'b0;
    localparam logic [23:0] MASK   = 24'h0000FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic [3:0]  io_in_rise;
    logic [3:0]  io_in_fall;
    logic [3:0]  io_out_rise;
    logic [3:0]  io_out_fall;
    logic [3:0]  io_oe;
    logic        mem_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  sr2;
    logic        cont_mode;

    logic [7:0]  mem [256];

    int   n_chk = 0;
    int   n_err = 0;
    logic m_qe;
    logic m_wel;
    logic m_cont;

    qspi_flash_responder #(
        .DUMMY_CYCLES (DUMMY),
        .QE_RESET     (QE_RST),
        .ADDR_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .io_in_rise  (io_in_rise),
        .io_in_fall  (io_in_fall),
        .io_out_rise (io_out_rise),
        .io_out_fall (io_out_fall),
        .io_oe       (io_oe),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .sr2         (sr2),
        .cont_mode   (cont_mode)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory, one cycle read latency
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr[7:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle, return at the next falling edge
    task automatic tick(input logic c, input logic [3:0] r, input logic [3:0] f);
        cs_n       = c;
        io_in_rise = r;
        io_in_fall = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cs_release(input int n);
        cs_n       = 1'b1;
        io_in_rise = 4'h0;
        io_in_fall = 4'h0;
        #1;
        chk("cs_gate_oe", io_oe, 4'h0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i < n; i++) tick(1'b1, 4'h0, 4'h0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, {3'b0, c[i]}, 4'($urandom_range(0, 15)));
            chk("cmd_oe", io_oe, 4'h0);
        end
    endtask

    task automatic wren();
        send_cmd(8'h06);
        m_wel = 1'b1;
        cs_release(1);
    endtask

    task automatic wrsr(input logic [7:0] d);
        send_cmd(8'h31);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, {3'b0, d[i]}, 4'h0);
            chk("wrsr_oe", io_oe, 4'h0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 4'($urandom_range(0, 15)), 4'h0);
        cs_release(1);
        if (m_wel) begin
            m_qe  = d[1];
            m_wel = 1'b0;
        end
        chk("wrsr_sr2", sr2, {6'b0, m_qe, 1'b0});
    endtask

    task automatic rdsr(input int n);
        logic [7:0] s;
        s = {6'b0, m_qe, 1'b0};
        send_cmd(8'h35);
        for (int j = 0; j < n; j++) begin
            tick(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            chk("rdsr_oe", io_oe, 4'b0010);
            chk("rdsr_rise", io_out_rise[1], s[7 - (j % 8)]);
            chk("rdsr_fall", io_out_fall[1], s[7 - (j % 8)]);
        end
        cs_release(1);
        chk("rdsr_sr2", sr2, s);
    endtask

    // Quad read. cut_at >= 0 interrupts the transaction just before cycle
    // cut_at, either by raising cs_n or by asserting reset.
    task automatic read_txn(input bit cont, input logic [23:0] addr, input logic [7:0] mb,
                            input int nbytes, input int cut_at, input bit cut_rst);
        logic [7:0] cmd;
        logic [7:0] ab;
        logic [7:0] exp_b;
        logic [7:0] idx;
        logic [3:0] r;
        logic [3:0] f;
        int         first;
        int         base;
        int         rel;
        bit         ok;
        bit         cut;
        cmd   = 8'hED;
        base  = cont ? 0 : 8;
        first = (cont ? 4 : 12) + DUMMY;
        ok    = cont || m_qe;
        cut   = 1'b0;
        for (int k = 0; k < first + nbytes && !cut; k++) begin
            if (k == cut_at) begin
                cut = 1'b1;
                if (cut_rst) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_oe", io_oe, 4'h0);
                    chk("rst_rise", io_out_rise, 4'h0);
                    chk("rst_fall", io_out_fall, 4'h0);
                    chk("rst_mem_en", mem_en, 1'b0);
                    chk("rst_mem_addr", mem_addr, 24'h0);
                    chk("rst_sr2", sr2, {6'b0, QE_RST, 1'b0});
                    chk("rst_cont", cont_mode, 1'b0);
                    m_qe   = QE_RST;
                    m_wel  = 1'b0;
                    m_cont = 1'b0;
                    @(negedge clk);
                    cs_n = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                end else begin
                    cs_n = 1'b1;
                    #1;
                    chk("abort_oe", io_oe, 4'h0);
                    @(posedge clk);
                    @(negedge clk);
                    chk("abort_oe_next", io_oe, 4'h0);
                end
            end else begin
                r   = 4'h0;
                f   = 4'h0;
                rel = k - base;
                if (!cont && k < 8) begin
                    r = {3'b0, cmd[7 - k]};
                end else if (rel < 3) begin
                    ab = 8'(addr >> (8 * (2 - rel)));
                    r  = ab[7:4];
                    f  = ab[3:0];
                end else if (rel == 3) begin
                    r = mb[7:4];
                    f = mb[3:0];
                end
                tick(1'b0, r, f);
                if (!ok) begin
                    chk("ign_oe", io_oe, 4'h0);
                    chk("ign_mem_en", mem_en, 1'b0);
                end else if (k < first) begin
                    chk("pre_oe", io_oe, 4'h0);
                end else begin
                    idx   = 8'((addr + 24'(k - first)) & MASK);
                    exp_b = mem[idx];
                    chk("data_oe", io_oe, 4'hF);
                    chk("data_rise", io_out_rise, exp_b[7:4]);
                    chk("data_fall", io_out_fall, exp_b[3:0]);
                    chk("addr_in_mask", mem_addr & ~MASK, 24'h0);
                end
                if (ok && rel == 3) m_cont = (mb[5:4] == 2'b10);
            end
        end
        cs_release(2);
        chk("cont_mode", cont_mode, m_cont);
    endtask

    initial begin
        reset      = 1'b1;
        cs_n       = 1'b1;
        io_in_rise = 4'h0;
        io_in_fall = 4'h0;
        m_qe       = QE_RST;
        m_wel      = 1'b0;
        m_cont     = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_oe", io_oe, 4'h0);
        chk("reset_rise", io_out_rise, 4'h0);
        chk("reset_fall", io_out_fall, 4'h0);
        chk("reset_mem_en", mem_en, 1'b0);
        chk("reset_mem_addr", mem_addr, 24'h0);
        chk("reset_sr2", sr2, {6'b0, QE_RST, 1'b0});
        chk("reset_cont", cont_mode, 1'b0);
        reset = 1'b0;
        tick(1'b1, 4'h0, 4'h0);
        tick(1'b1, 4'h0, 4'h0);

        // Quad read refused while QE=0: 40 cycles with nothing driven
        read_txn(1'b0, 24'h000010, 8'h00, 40 - (12 + DUMMY), -1, 1'b0);

        // Set QE, read it back; a WRSR without WREN must not change it
        wren();
        wrsr(8'h02);
        rdsr(16);
        wrsr(8'h00);
        rdsr(8);

        // Command-entry read, mode byte leaves continuous mode off
        read_txn(1'b0, 24'h000010, 8'h00, 3, -1, 1'b0);

        // Arm continuous mode, then an address-only read that wraps at the mask
        read_txn(1'b0, 24'h000033, 8'h20, 2, -1, 1'b0);
        read_txn(1'b1, 24'h0000FE, 8'h20, 3, -1, 1'b0);
        read_txn(1'b1, 24'h000080, 8'h00, 2, -1, 1'b0);

        // Deselect during the dummy phase, then a fresh command
        read_txn(1'b0, 24'h000020, 8'h00, 2, 14, 1'b0);
        rdsr(8);

        // Randomized mix over random memory contents
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int it = 0; it < 25; it++) begin
            if (m_cont) begin
                read_txn(1'b1, 24'($urandom()), 8'($urandom_range(0, 255)),
                         $urandom_range(1, 6), -1, 1'b0);
            end else begin
                case ($urandom_range(0, 4))
                    0: wren();
                    1: wrsr(8'($urandom_range(0, 255)));
                    2: rdsr($urandom_range(1, 12));
                    default: read_txn(1'b0, 24'($urandom()), 8'($urandom_range(0, 255)),
                                      $urandom_range(1, 6), -1, 1'b0);
                endcase
            end
        end

        // Reset in the middle of the data phase
        if (m_cont) read_txn(1'b1, 24'h000000, 8'h00, 1, -1, 1'b0);
        wren();
        wrsr(8'h02);
        read_txn(1'b0, 24'h000040, 8'h00, 4, 12 + DUMMY + 2, 1'b1);
        read_txn(1'b0, 24'h000040, 8'h00, 2, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
